// File: rtl/full_adder_checker_pkg.sv
// Shared types and constants for the full-adder response checker.
package full_adder_checker_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_chk_ref.sv
// Combinational arithmetic reference: expected {c_out, s} for a + b + c_in and a mismatch flag.
module fa_chk_ref #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_out_i,
    output logic [WIDTH:0]   exp_sum_c,
    output logic             mismatch_c
);

    localparam int unsigned SUM_W = WIDTH + 1;

    // Widen before adding so the carry out of the top bit is kept.
    always_comb begin
        exp_sum_c  = SUM_W'(a_i) + SUM_W'(b_i) + SUM_W'(c_in_i);
        mismatch_c = ({c_out_i, s_i} != exp_sum_c);
    end

endmodule

// File: rtl/full_adder_checker.sv
// Full-adder response checker: counts accepted and mismatching tuples over a run of NUM_VECTORS.
// Optional first-failure capture is enabled by defining FULL_ADDER_CHECKER_CAPTURE_EN.
module full_adder_checker
    import full_adder_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned NUM_VECTORS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH-1:0] s,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_cnt,
    output logic [15:0]      fail_cnt,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_s,
    output logic             first_fail_c_in,
    output logic             first_fail_c_out,
    output logic             first_fail_vld
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             hs_c;
    logic             start_run_c;
    logic             mismatch_c;
    logic [WIDTH:0]   exp_sum_c;

    fa_chk_ref #(.WIDTH(WIDTH)) u_ref (
        .a_i        (a),
        .b_i        (b),
        .c_in_i     (c_in),
        .s_i        (s),
        .c_out_i    (c_out),
        .exp_sum_c  (exp_sum_c),
        .mismatch_c (mismatch_c)
    );

    // The flag and the expected sum come from the same reference and must agree.
    always_comb begin
        assert (mismatch_c == ({c_out, s} != exp_sum_c));
    end

    always_comb begin
        hs_c        = (state_q == RUN) && sample_valid;
        start_run_c = ((state_q == IDLE) || (state_q == DONE)) && start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (hs_c && (vec_cnt_q == LAST_IDX)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the counters.
    always_comb begin
        ready_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        pass_d  = (state_d == DONE) && (fail_cnt_d == '0);
    end

    always_comb begin
        vec_cnt_d  = vec_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (start_run_c) begin
            vec_cnt_d  = '0;
            fail_cnt_d = '0;
        end else if (hs_c) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
            if (mismatch_c && (fail_cnt_q != CNT_MAX)) begin
                fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt_q  <= '0;
            fail_cnt_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            vec_cnt_q  <= vec_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign sample_ready = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign vec_cnt      = vec_cnt_q;
    assign fail_cnt     = fail_cnt_q;

`ifdef FULL_ADDER_CHECKER_CAPTURE_EN
    logic             cap_vld_q;
    logic [CNT_W-1:0] cap_idx_q;
    logic [WIDTH-1:0] cap_a_q, cap_b_q, cap_s_q;
    logic             cap_c_in_q, cap_c_out_q;

    // Latch only the first mismatching tuple of a run; index is the pre-increment count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_s_q     <= '0;
            cap_c_in_q  <= 1'b0;
            cap_c_out_q <= 1'b0;
        end else if (start_run_c) begin
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_s_q     <= '0;
            cap_c_in_q  <= 1'b0;
            cap_c_out_q <= 1'b0;
        end else if (hs_c && mismatch_c && !cap_vld_q) begin
            cap_vld_q   <= 1'b1;
            cap_idx_q   <= vec_cnt_q;
            cap_a_q     <= a;
            cap_b_q     <= b;
            cap_s_q     <= s;
            cap_c_in_q  <= c_in;
            cap_c_out_q <= c_out;
        end
    end

    assign first_fail_vld   = cap_vld_q;
    assign first_fail_idx   = cap_idx_q;
    assign first_fail_a     = cap_a_q;
    assign first_fail_b     = cap_b_q;
    assign first_fail_s     = cap_s_q;
    assign first_fail_c_in  = cap_c_in_q;
    assign first_fail_c_out = cap_c_out_q;
`else
    assign first_fail_vld   = 1'b0;
    assign first_fail_idx   = '0;
    assign first_fail_a     = '0;
    assign first_fail_b     = '0;
    assign first_fail_s     = '0;
    assign first_fail_c_in  = 1'b0;
    assign first_fail_c_out = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_checker.sv
// Randomized bench for full_adder_checker: a 1-bit/8-vector instance and a 4-bit/65535-vector instance.
module tb_full_adder_checker;

    localparam int unsigned NV_A = 8;
    localparam int unsigned W_B  = 4;
    localparam int unsigned NV_B = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st_a = 1'b0, v_a = 1'b0, a_a = 1'b0, b_a = 1'b0, ci_a = 1'b0, s_a = 1'b0, co_a = 1'b0;
    logic        rdy_a, busy_a, done_a, pass_a;
    logic [15:0] vcnt_a, fcnt_a, ffi_a;
    logic        ffa_a, ffb_a, ffs_a, ffci_a, ffco_a, ffv_a;

    logic        st_b = 1'b0, v_b = 1'b0, ci_b = 1'b0, co_b = 1'b0;
    logic [3:0]  a_b = '0, b_b = '0, s_b = '0;
    logic        rdy_b, busy_b, done_b, pass_b;
    logic [15:0] vcnt_b, fcnt_b, ffi_b;
    logic [3:0]  ffa_b, ffb_b, ffs_b;
    logic        ffci_b, ffco_b, ffv_b;

    full_adder_checker #(.WIDTH(1), .NUM_VECTORS(NV_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(st_a), .sample_valid(v_a), .sample_ready(rdy_a),
        .a(a_a), .b(b_a), .c_in(ci_a), .s(s_a), .c_out(co_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vcnt_a), .fail_cnt(fcnt_a),
        .first_fail_idx(ffi_a), .first_fail_a(ffa_a), .first_fail_b(ffb_a), .first_fail_s(ffs_a),
        .first_fail_c_in(ffci_a), .first_fail_c_out(ffco_a), .first_fail_vld(ffv_a)
    );

    full_adder_checker #(.WIDTH(W_B), .NUM_VECTORS(NV_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(st_b), .sample_valid(v_b), .sample_ready(rdy_b),
        .a(a_b), .b(b_b), .c_in(ci_b), .s(s_b), .c_out(co_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vcnt_b), .fail_cnt(fcnt_b),
        .first_fail_idx(ffi_b), .first_fail_a(ffa_b), .first_fail_b(ffb_b), .first_fail_s(ffs_b),
        .first_fail_c_in(ffci_b), .first_fail_c_out(ffco_b), .first_fail_vld(ffv_b)
    );

    // Transaction-level expectation of one checker: run flag, counts, first-failure record.
    typedef struct {
        bit run;
        bit done;
        int vec;
        int fail;
        bit cvld;
        int cidx, ca, cb, cs, cci, cco;
    } mdl_t;

    mdl_t ma, mb;
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;

    function automatic mdl_t mstep(mdl_t m, int nv, int w, bit st, bit v,
                                   int a, int b, int ci, int s, int co);
        mdl_t r = m;
        if (r.run) begin
            if (v) begin
                if (a + b + ci != co * (1 << w) + s) begin
                    if (r.fail < 65535) r.fail++;
                    if (!r.cvld) begin
                        r.cvld = 1'b1; r.cidx = r.vec;
                        r.ca = a; r.cb = b; r.cs = s; r.cci = ci; r.cco = co;
                    end
                end
                r.vec++;
                if (r.vec == nv) begin
                    r.run  = 1'b0;
                    r.done = 1'b1;
                end
            end
        end else if (st) begin
            r     = '{default: 0};
            r.run = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_a();
        chk("a.ready", 32'(rdy_a), 32'(ma.run));
        chk("a.busy", 32'(busy_a), 32'(ma.run));
        chk("a.done", 32'(done_a), 32'(ma.done));
        chk("a.pass", 32'(pass_a), 32'(ma.done && ma.fail == 0));
        chk("a.vec_cnt", 32'(vcnt_a), 32'(ma.vec));
        chk("a.fail_cnt", 32'(fcnt_a), 32'(ma.fail));
`ifdef FULL_ADDER_CHECKER_CAPTURE_EN
        chk("a.ff_vld", 32'(ffv_a), 32'(ma.cvld));
        chk("a.ff_idx", 32'(ffi_a), 32'(ma.cidx));
        chk("a.ff_tuple", {27'd0, ffa_a, ffb_a, ffci_a, ffs_a, ffco_a},
            32'({ma.ca[0], ma.cb[0], ma.cci[0], ma.cs[0], ma.cco[0]}));
`else
        chk("a.ff_vld", 32'(ffv_a), 32'd0);
        chk("a.ff_idx", 32'(ffi_a), 32'd0);
        chk("a.ff_tuple", {27'd0, ffa_a, ffb_a, ffci_a, ffs_a, ffco_a}, 32'd0);
`endif
    endtask

    task automatic check_b();
        chk("b.ready", 32'(rdy_b), 32'(mb.run));
        chk("b.busy", 32'(busy_b), 32'(mb.run));
        chk("b.done", 32'(done_b), 32'(mb.done));
        chk("b.pass", 32'(pass_b), 32'(mb.done && mb.fail == 0));
        chk("b.vec_cnt", 32'(vcnt_b), 32'(mb.vec));
        chk("b.fail_cnt", 32'(fcnt_b), 32'(mb.fail));
`ifdef FULL_ADDER_CHECKER_CAPTURE_EN
        chk("b.ff_vld", 32'(ffv_b), 32'(mb.cvld));
        chk("b.ff_idx", 32'(ffi_b), 32'(mb.cidx));
        chk("b.ff_tuple", {18'd0, ffa_b, ffb_b, ffs_b, ffci_b, ffco_b},
            {18'd0, 4'(mb.ca), 4'(mb.cb), 4'(mb.cs), 1'(mb.cci), 1'(mb.cco)});
`else
        chk("b.ff_vld", 32'(ffv_b), 32'd0);
        chk("b.ff_idx", 32'(ffi_b), 32'd0);
        chk("b.ff_tuple", {18'd0, ffa_b, ffb_b, ffs_b, ffci_b, ffco_b}, 32'd0);
`endif
    endtask

    // Random tuple of width w; when bad, the sum or the carry is corrupted.
    task automatic gen(input int w, input bit bad, output int a, output int b, output int ci,
                       output int s, output int co);
        int sum;
        a   = int'($urandom_range((1 << w) - 1, 0));
        b   = int'($urandom_range((1 << w) - 1, 0));
        ci  = int'($urandom_range(1, 0));
        sum = a + b + ci;
        s   = sum % (1 << w);
        co  = sum >> w;
        if (bad) begin
            if ($urandom_range(1, 0) == 1) co = co ^ 1;
            else s = s ^ int'($urandom_range((1 << w) - 1, 1));
        end
    endtask

    // Inputs are driven at the falling edge and outputs compared at the next falling edge.
    task automatic step_a(input bit st, input bit v, input int a, input int b, input int ci,
                          input int s, input int co);
        st_a = st; v_a = v; a_a = 1'(a); b_a = 1'(b); ci_a = 1'(ci); s_a = 1'(s); co_a = 1'(co);
        @(posedge clk);
        if (ma.run && v) n_vec++;
        ma = mstep(ma, NV_A, 1, st, v, a, b, ci, s, co);
        @(negedge clk);
        st_a = 1'b0; v_a = 1'b0;
        check_a();
    endtask

    task automatic step_b(input bit st, input bit v, input int a, input int b, input int ci,
                          input int s, input int co);
        st_b = st; v_b = v; a_b = 4'(a); b_b = 4'(b); ci_b = 1'(ci); s_b = 4'(s); co_b = 1'(co);
        @(posedge clk);
        if (mb.run && v) n_vec++;
        mb = mstep(mb, NV_B, W_B, st, v, a, b, ci, s, co);
        @(negedge clk);
        st_b = 1'b0; v_b = 1'b0;
        check_b();
    endtask

    task automatic rand_a(input bit st, input bit v, input bit bad);
        int a, b, ci, s, co;
        gen(1, bad, a, b, ci, s, co);
        step_a(st, v, a, b, ci, s, co);
    endtask

    // Reset is raised between edges; outputs must clear before any clock arrives.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        check_a();
        check_b();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int a, b, ci, s, co;
        ma = '{default: 0};
        mb = '{default: 0};

        @(negedge clk);
        check_a();
        check_b();
        rst = 1'b0;

        // Exhaustive correct run on the 1-bit instance
        step_a(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            a = (i >> 2) & 1; b = (i >> 1) & 1; ci = i & 1;
            step_a(0, 1, a, b, ci, (a + b + ci) % 2, (a + b + ci) / 2);
        end
        chk("run1.pass", 32'(pass_a), 32'd1);
        step_a(0, 1, 1, 1, 1, 0, 0);

        // Sum bit flipped on vectors 3 and 6
        step_a(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            a = (i >> 2) & 1; b = (i >> 1) & 1; ci = i & 1;
            s = (a + b + ci) % 2;
            if (i == 3 || i == 6) s = s ^ 1;
            step_a(0, 1, a, b, ci, s, (a + b + ci) / 2);
        end
        chk("run2.fail_cnt", 32'(fcnt_a), 32'd2);
        chk("run2.pass", 32'(pass_a), 32'd0);

        // Start and valid together in DONE: only the start takes effect
        step_a(1, 1, 1, 1, 1, 0, 0);
        chk("restart.vec_cnt", 32'(vcnt_a), 32'd0);

        // Gapped valid with a start pulse in RUN
        for (int i = 0; i < 40 && ma.run; i++) begin
            rand_a(i == 3, (i % 2) == 0, $urandom_range(3, 0) == 0);
        end
        step_a(0, 0, 0, 0, 0, 0, 0);

        // Reset after five accepted vectors, then a complete run
        step_a(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) rand_a(0, 1, $urandom_range(3, 0) == 0);
        mid_reset();
        step_a(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) rand_a(0, 1, $urandom_range(3, 0) == 0);
        chk("after_rst.done", 32'(done_a), 32'd1);

        // Free-running random traffic
        for (int i = 0; i < 400; i++) begin
            rand_a($urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0);
        end

        // 4-bit carry-through boundary
        step_b(1, 0, 0, 0, 0, 0, 0);
        step_b(0, 1, 15, 1, 1, 1, 1);
        chk("w4.ok.fail_cnt", 32'(fcnt_b), 32'd0);
        step_b(0, 1, 15, 1, 1, 1, 0);
        chk("w4.bad.fail_cnt", 32'(fcnt_b), 32'd1);
        for (int i = 0; i < 30; i++) begin
            gen(W_B, $urandom_range(3, 0) == 0, a, b, ci, s, co);
            step_b($urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1, a, b, ci, s, co);
        end
        mid_reset();

        // Every vector wrong over a maximum-length run
        step_b(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000 && mb.run; i++) begin
            gen(W_B, 1'b1, a, b, ci, s, co);
            step_b(0, 1, a, b, ci, s, co);
        end
        chk("sat.fail_cnt", 32'(fcnt_b), 32'h0000FFFF);
        chk("sat.done", 32'(done_b), 32'd1);
        chk("sat.pass", 32'(pass_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
